psg_core_stereo: RTL and testbench

Parametrised successor to the team's SN76489-compatible sound generator. It provides 1–3 square-wave tone channels and one noise channel with a configurable LFSR. It adds a clock prescaler, a strobed write port with READY back-pressure, and a Game-Gear-style stereo pan register. Outputs are registered, saturated left and right master samples that feed the pad-level audio path.

---
 rtl/psg_core_stereo_if.sv | 22 ++
 rtl/psg_core_stereo.sv | 204 ++++++++++++++++++++
 tb/tb_psg_core_stereo.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/psg_core_stereo_if.sv
// Write port and stereo sample bus of psg_core_stereo.
// The host side drives the write strobes; the generator returns ready and the two samples.
interface psg_core_stereo_if #(
  parameter int unsigned MASTER_OUTPUT_BITS = 7
);
  logic [7:0]                    data_in;
  logic                          wr;
  logic                          pan_wr;
  logic                          ready;
  logic [MASTER_OUTPUT_BITS-1:0] audio_l;
  logic [MASTER_OUTPUT_BITS-1:0] audio_r;

  modport master (
    output data_in, wr, pan_wr,
    input  ready, audio_l, audio_r
  );

  modport slave (
    input  data_in, wr, pan_wr,
    output ready, audio_l, audio_r
  );
endinterface

// File: rtl/psg_core_stereo.sv
// SN76489-style sound generator: up to three tone channels, one LFSR noise channel,
// clock prescaler, write back-pressure and a per-channel stereo pan mixer.
module psg_core_stereo #(
  parameter int unsigned          NUM_TONES           = 3,
  parameter int unsigned          CLOCK_DIV           = 16,
  parameter int unsigned          CHANNEL_OUTPUT_BITS = 8,
  parameter int unsigned          MASTER_OUTPUT_BITS  = 7,
  parameter int unsigned          LFSR_BITS           = 16,
  parameter logic [LFSR_BITS-1:0] WHITE_TAPS          = 16'h0009,
  parameter int unsigned          WRITE_BUSY_CYCLES   = 4
) (
  input logic              clk,
  input logic              reset,
  psg_core_stereo_if.slave bus
);

  localparam int unsigned PresW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam int unsigned BusyW = (WRITE_BUSY_CYCLES > 0) ? $clog2(WRITE_BUSY_CYCLES + 1) : 1;
  localparam int unsigned AccW  = CHANNEL_OUTPUT_BITS + 2;
  localparam logic [LFSR_BITS-1:0] LfsrReload = {1'b1, {(LFSR_BITS - 1){1'b0}}};

  logic [PresW-1:0]                presc_q;
  logic                            tick;
  logic [BusyW-1:0]                busy_q;
  logic                            ready;
  logic [NUM_TONES-1:0][9:0]       freq_q;
  logic [NUM_TONES-1:0][9:0]       tone_cnt_q;
  logic [NUM_TONES-1:0]            tone_out_q;
  logic [3:0]                      attn_q [4];
  logic [2:0]                      latch_q;
  logic [7:0]                      pan_q;
  logic [2:0]                      noise_ctrl_q;
  logic [9:0]                      noise_cnt_q, noise_cnt_d, noise_rate;
  logic                            noise_tog_q, noise_tog_d, noise_shift;
  logic [LFSR_BITS-1:0]            lfsr_q;
  logic                            lfsr_fb;
  logic [MASTER_OUTPUT_BITS-1:0]   audio_l_q, audio_r_q, audio_l_d, audio_r_d;

  // Write decode: data bytes reuse the address/type held in the latch register.
  logic       accept, pan_we, reg_we, is_latch, wr_type, addr_ok;
  logic [1:0] wr_addr;
  logic       attn_we, freq_lo_we, freq_hi_we, noise_we;

  assign tick  = (presc_q == PresW'(CLOCK_DIV - 1));
  assign ready = (busy_q == '0);

  always_comb begin
    accept     = (bus.wr | bus.pan_wr) & ready;
    pan_we     = accept & bus.pan_wr;
    reg_we     = accept & ~bus.pan_wr;
    is_latch   = bus.data_in[7];
    wr_addr    = is_latch ? bus.data_in[6:5] : latch_q[2:1];
    wr_type    = is_latch ? bus.data_in[4] : latch_q[0];
    addr_ok    = (wr_addr == 2'd3) || (32'(wr_addr) < NUM_TONES);
    attn_we    = reg_we & wr_type & addr_ok;
    freq_lo_we = reg_we & ~wr_type & is_latch & (32'(wr_addr) < NUM_TONES);
    freq_hi_we = reg_we & ~wr_type & ~is_latch & (32'(wr_addr) < NUM_TONES);
    noise_we   = reg_we & ~wr_type & (wr_addr == 2'd3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      busy_q  <= '0;
      latch_q <= '0;
      pan_q   <= 8'hFF;
      for (int i = 0; i < 4; i++) attn_q[i] <= 4'd15;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (accept && (WRITE_BUSY_CYCLES > 0)) begin
        busy_q <= BusyW'(WRITE_BUSY_CYCLES);
      end else if (busy_q != '0) begin
        busy_q <= busy_q - 1'b1;
      end
      if (reg_we && is_latch) latch_q <= bus.data_in[6:4];
      if (pan_we) pan_q <= bus.data_in;
      if (attn_we) attn_q[wr_addr] <= bus.data_in[3:0];
    end
  end

  // Tone channels; a new period is only picked up when the counter reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_q     <= '0;
      tone_cnt_q <= '0;
      tone_out_q <= '1;
    end else begin
      for (int i = 0; i < int'(NUM_TONES); i++) begin
        if (freq_lo_we && (32'(wr_addr) == i)) freq_q[i][3:0] <= bus.data_in[3:0];
        if (freq_hi_we && (32'(wr_addr) == i)) freq_q[i][9:4] <= bus.data_in[5:0];
        if (tick) begin
          if (freq_q[i] <= 10'd1) begin
            tone_out_q[i] <= 1'b1;
          end else if (tone_cnt_q[i] <= 10'd1) begin
            tone_cnt_q[i] <= freq_q[i];
            tone_out_q[i] <= ~tone_out_q[i];
          end else begin
            tone_cnt_q[i] <= tone_cnt_q[i] - 10'd1;
          end
        end
      end
    end
  end

  always_comb begin
    unique case (noise_ctrl_q[1:0])
      2'b00:   noise_rate = 10'd16;
      2'b01:   noise_rate = 10'd32;
      2'b10:   noise_rate = 10'd64;
      default: noise_rate = freq_q[NUM_TONES-1];
    endcase
    noise_cnt_d = noise_cnt_q;
    noise_tog_d = noise_tog_q;
    if (tick) begin
      if (noise_rate <= 10'd1) begin
        noise_tog_d = 1'b1;
      end else if (noise_cnt_q <= 10'd1) begin
        noise_cnt_d = noise_rate;
        noise_tog_d = ~noise_tog_q;
      end else begin
        noise_cnt_d = noise_cnt_q - 10'd1;
      end
    end
    noise_shift = ~noise_tog_q & noise_tog_d;
    lfsr_fb     = noise_ctrl_q[2] ? ^(lfsr_q & WHITE_TAPS) : lfsr_q[0];
  end

  // A noise register write reloads the LFSR even if a shift lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      noise_ctrl_q <= 3'b100;
      noise_cnt_q  <= '0;
      noise_tog_q  <= 1'b1;
      lfsr_q       <= LfsrReload;
    end else begin
      noise_cnt_q <= noise_cnt_d;
      noise_tog_q <= noise_tog_d;
      if (noise_we) begin
        noise_ctrl_q <= bus.data_in[2:0];
        lfsr_q       <= LfsrReload;
      end else if (noise_shift) begin
        lfsr_q <= {lfsr_fb, lfsr_q[LFSR_BITS-1:1]};
      end
    end
  end

  function automatic logic [CHANNEL_OUTPUT_BITS-1:0] vol(input logic [3:0] a);
    logic [7:0] v8;
    unique case (a)
      4'd0:  v8 = 8'd255;
      4'd1:  v8 = 8'd203;
      4'd2:  v8 = 8'd161;
      4'd3:  v8 = 8'd128;
      4'd4:  v8 = 8'd102;
      4'd5:  v8 = 8'd81;
      4'd6:  v8 = 8'd64;
      4'd7:  v8 = 8'd51;
      4'd8:  v8 = 8'd40;
      4'd9:  v8 = 8'd32;
      4'd10: v8 = 8'd26;
      4'd11: v8 = 8'd20;
      4'd12: v8 = 8'd16;
      4'd13: v8 = 8'd13;
      4'd14: v8 = 8'd10;
      default: v8 = 8'd0;
    endcase
    return CHANNEL_OUTPUT_BITS'(v8) << (CHANNEL_OUTPUT_BITS - 8);
  endfunction

  logic [3:0]                     chan_bit;
  logic [CHANNEL_OUTPUT_BITS-1:0] level;
  logic [AccW-1:0]                sum_l, sum_r;

  always_comb begin
    chan_bit = {lfsr_q[0], 3'(tone_out_q)};
    sum_l    = '0;
    sum_r    = '0;
    level    = '0;
    for (int i = 0; i < 4; i++) begin
      level = chan_bit[i] ? vol(attn_q[i]) : '0;
      if (pan_q[4+i]) sum_l = sum_l + AccW'(level);
      if (pan_q[i])   sum_r = sum_r + AccW'(level);
    end
    audio_l_d = (sum_l[AccW-1:CHANNEL_OUTPUT_BITS] != '0) ? '1
              : sum_l[CHANNEL_OUTPUT_BITS-1 -: MASTER_OUTPUT_BITS];
    audio_r_d = (sum_r[AccW-1:CHANNEL_OUTPUT_BITS] != '0) ? '1
              : sum_r[CHANNEL_OUTPUT_BITS-1 -: MASTER_OUTPUT_BITS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else begin
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
    end
  end

  assign bus.ready   = ready;
  assign bus.audio_l = audio_l_q;
  assign bus.audio_r = audio_r_q;

endmodule

// File: tb/tb_psg_core_stereo.sv
// Directed bench for psg_core_stereo: CLOCK_DIV=1, four-cycle write busy window,
// hand-computed tone, pan, noise, mixer and saturation values.
module tb_psg_core_stereo;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  psg_core_stereo_if #(.MASTER_OUTPUT_BITS(7)) bus ();

  psg_core_stereo #(
    .NUM_TONES          (3),
    .CLOCK_DIV          (1),
    .CHANNEL_OUTPUT_BITS(8),
    .MASTER_OUTPUT_BITS (7),
    .LFSR_BITS          (16),
    .WHITE_TAPS         (16'h0009),
    .WRITE_BUSY_CYCLES  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic pan);
    int n = 0;
    while (!bus.ready && n < 20) begin
      step();
      n++;
    end
    check("ready_before_write", 32'(bus.ready), 32'd1);
    bus.data_in = b;
    bus.wr      = ~pan;
    bus.pan_wr  = pan;
    step();
    bus.wr      = 1'b0;
    bus.pan_wr  = 1'b0;
  endtask

  initial begin
    int          n;
    int          highs;
    int          t0;
    logic [31:0] prev;
    logic [31:0] v;
    logic [31:0] exp;

    reset       = 1'b1;
    bus.data_in = 8'h00;
    bus.wr      = 1'b0;
    bus.pan_wr  = 1'b0;
    repeat (3) step();
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_audio_l", 32'(bus.audio_l), 32'd0);
    check("reset_audio_r", 32'(bus.audio_r), 32'd0);
    reset = 1'b0;

    // Idle after reset: silent, always ready.
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_ready", 32'(bus.ready), 32'd1);
      check("idle_audio_l", 32'(bus.audio_l), 32'd0);
      check("idle_audio_r", 32'(bus.audio_r), 32'd0);
    end

    // Tone0 period 3 at full volume: 127/0 square, 3 cycles per level.
    write_byte(8'h83, 1'b0);
    write_byte(8'h00, 1'b0);
    write_byte(8'h90, 1'b0);
    repeat (3) step();
    prev = 32'(bus.audio_l);
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (32'(bus.audio_l) != prev) break;
    end
    check("tone_edge_found", 32'(n < 10), 32'd1);
    v = 32'(bus.audio_l);
    check("tone_level_valid", 32'((v == 0) || (v == 127)), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (((k / 3) % 2) == 0) ? v : 32'd127 - v;
      check("tone_wave_l", 32'(bus.audio_l), exp);
      check("tone_wave_r", 32'(bus.audio_r), exp);
    end

    // Pan 0x10: tone0 on the left only.
    write_byte(8'h10, 1'b1);
    repeat (2) step();
    highs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("pan_r_silent", 32'(bus.audio_r), 32'd0);
      check("pan_l_valid", 32'((bus.audio_l == 7'd0) || (bus.audio_l == 7'd127)), 32'd1);
      if (bus.audio_l == 7'd127) highs++;
    end
    check("pan_l_duty", 32'(highs), 32'd3);

    // wr held two cycles: 0x9F accepted, 0x90 dropped while busy.
    n = 0;
    while (!bus.ready && n < 20) begin
      step();
      n++;
    end
    bus.data_in = 8'h9F;
    bus.wr      = 1'b1;
    step();
    check("busy_edge1", 32'(bus.ready), 32'd0);
    bus.data_in = 8'h90;
    step();
    bus.wr = 1'b0;
    check("busy_edge2", 32'(bus.ready), 32'd0);
    step();
    check("busy_edge3", 32'(bus.ready), 32'd0);
    step();
    check("busy_edge4", 32'(bus.ready), 32'd0);
    step();
    check("busy_release", 32'(bus.ready), 32'd1);
    repeat (2) step();
    for (int k = 0; k < 12; k++) begin
      step();
      check("dropped_write_l", 32'(bus.audio_l), 32'd0);
    end

    // Periodic noise at rate 16: high for 32 of every 512 cycles.
    write_byte(8'hFF, 1'b1);
    write_byte(8'hE0, 1'b0);
    write_byte(8'hF0, 1'b0);
    n = 0;
    while (bus.audio_l != 7'd127 && n < 700) begin
      step();
      n++;
    end
    check("noise_rise_found", 32'(bus.audio_l), 32'd127);
    check("noise_r_high", 32'(bus.audio_r), 32'd127);
    n = 1;
    while (n < 100) begin
      step();
      if (bus.audio_l != 7'd127) break;
      n++;
    end
    check("noise_high_run", 32'(n), 32'd32);
    n = 1;
    while (n < 1000) begin
      step();
      if (bus.audio_l == 7'd127) break;
      n++;
    end
    check("noise_low_run", 32'(n), 32'd480);
    t0 = cyc;
    repeat (32) step();
    check("noise_fall", 32'(bus.audio_l), 32'd0);

    // Mixer during the noise-low phase: tone0 held high at attn 3 (128), tone1 at attn 5 (81).
    write_byte(8'h81, 1'b0);
    write_byte(8'h93, 1'b0);
    write_byte(8'hB5, 1'b0);
    repeat (2) step();
    check("mix_l_209", 32'(bus.audio_l), 32'd104);
    check("mix_r_209", 32'(bus.audio_r), 32'd104);
    write_byte(8'h21, 1'b1);
    repeat (2) step();
    check("pan_split_l", 32'(bus.audio_l), 32'd40);
    check("pan_split_r", 32'(bus.audio_r), 32'd64);
    write_byte(8'hFF, 1'b1);
    write_byte(8'h90, 1'b0);
    write_byte(8'hB0, 1'b0);
    write_byte(8'hD0, 1'b0);
    repeat (2) step();
    check("sat3_l", 32'(bus.audio_l), 32'd127);
    check("sat3_r", 32'(bus.audio_r), 32'd127);
    check("sat_window_ok", 32'(cyc < t0 + 500), 32'd1);
    while (cyc < t0 + 520) step();
    check("sat4_l", 32'(bus.audio_l), 32'd127);
    check("sat4_r", 32'(bus.audio_r), 32'd127);

    // Asynchronous reset in the middle of a busy window.
    write_byte(8'h9F, 1'b0);
    check("pre_reset_busy", 32'(bus.ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ready", 32'(bus.ready), 32'd1);
    check("async_reset_l", 32'(bus.audio_l), 32'd0);
    check("async_reset_r", 32'(bus.audio_r), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_reset_ready", 32'(bus.ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
